// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between ALU writeback (priority) and a load-return FIFO.
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_wr,
    input  logic [DW-1:0]            alu_wd,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [AW-1:0]            ld_wr,
    input  logic [DW-1:0]            ld_wd,
    output logic                     write,
    output logic [AW-1:0]            WR,
    output logic [DW-1:0]            WD,
    output logic [2**AW-1:0]         pend_mask,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int NR = 2**AW;

    logic [AW-1:0]    wr_mem_q [DEPTH];
    logic [AW-1:0]    wr_mem_d [DEPTH];
    logic [DW-1:0]    wd_mem_q [DEPTH];
    logic [DW-1:0]    wd_mem_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    logic             fresh_q, fresh_d, write_q, write_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [DW-1:0]    wd_q, wd_d;
    logic [NR-1:0]    pend_q, pend_d;
    logic             alu_hit, push, head_vis, head_drain, pop;

    assign ld_ready = !reset && (count_q < (PW+1)'(DEPTH));

    always_comb begin
        alu_hit = alu_valid && (alu_wr != '0);
        push = ld_valid && ld_ready;
        // an entry pushed at the last edge is not eligible until the following cycle
        head_vis = (count_q != '0) && !((count_q == (PW+1)'(1)) && fresh_q);
        head_drain = head_vis && live_q[head_q] && !alu_hit;
        pop = head_vis && (!live_q[head_q] || !alu_hit);
        write_d = alu_hit || head_drain;
        wr_d = alu_hit ? alu_wr : head_drain ? wr_mem_q[head_q] : wr_q;
        wd_d = alu_hit ? alu_wd : head_drain ? wd_mem_q[head_q] : wd_q;
        head_d = head_q + PW'(pop);
        tail_d = tail_q + PW'(push);
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        fresh_d = push;
        wr_mem_d = wr_mem_q;
        wd_mem_d = wd_mem_q;
        for (int i = 0; i < DEPTH; i++)
            live_d[i] = live_q[i] && !(alu_hit && (wr_mem_q[i] == alu_wr)) && !(pop && (PW'(i) == head_q));
        if (push) begin
            wr_mem_d[tail_q] = ld_wr;
            wd_mem_d[tail_q] = ld_wd;
            live_d[tail_q] = ld_wr != '0;
        end
        pend_d = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live_d[i]) pend_d[wr_mem_d[i]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        wr_mem_q <= wr_mem_d;
        wd_mem_q <= wd_mem_d;
        if (reset) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fresh_q <= 1'b0;
            write_q <= 1'b0;
            wr_q    <= '0;
            wd_q    <= '0;
            pend_q  <= '0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fresh_q <= fresh_d;
            write_q <= write_d;
            wr_q    <= wr_d;
            wd_q    <= wd_d;
            pend_q  <= pend_d;
        end
    end

    assign write     = write_q;
    assign WR        = wr_q;
    assign WD        = wd_q;
    assign pend_mask = pend_q;
    assign q_count   = count_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_write_arbiter;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2**AW;

    logic clk = 1'b0;
    logic reset, alu_valid, ld_valid, ld_ready, write;
    logic [AW-1:0] alu_wr, ld_wr, WR;
    logic [DW-1:0] alu_wd, ld_wd, WD;
    logic [NR-1:0] pend_mask;
    logic [2:0]    q_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        bit            live;
        int            t;
    } ent_t;
    ent_t          mq[$];
    int            edge_n = 0;
    bit            m_write = 0;
    logic [AW-1:0] m_wr = '0;
    logic [DW-1:0] m_wd = '0;

    wb_write_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_wr(alu_wr), .alu_wd(alu_wd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wr(ld_wr), .ld_wd(ld_wd),
        .write(write), .WR(WR), .WD(WD), .pend_mask(pend_mask), .q_count(q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [NR-1:0] m_pend();
        logic [NR-1:0] p = '0;
        foreach (mq[i]) if (mq[i].live) p[mq[i].wr] = 1'b1;
        return p;
    endfunction

    task automatic set_in(input bit av, input int aw, input logic [DW-1:0] awd,
                          input bit lv, input int lw, input logic [DW-1:0] lwd);
        alu_valid = av; alu_wr = AW'(aw); alu_wd = awd;
        ld_valid = lv; ld_wr = AW'(lw); ld_wd = lwd;
    endtask

    // advance one edge, update the model from the rules, then settle 1 time unit past the edge
    task automatic cyc();
        bit hit, vis, psh;
        @(posedge clk);
        edge_n++;
        if (reset) begin
            mq.delete();
            m_write = 0; m_wr = '0; m_wd = '0;
        end else begin
            hit = alu_valid && (alu_wr != '0);
            vis = (mq.size() > 0) && (mq[0].t < edge_n - 1);
            psh = ld_valid && (mq.size() < DEPTH);
            if (hit) begin
                m_write = 1; m_wr = alu_wr; m_wd = alu_wd;
            end else if (vis && mq[0].live) begin
                m_write = 1; m_wr = mq[0].wr; m_wd = mq[0].wd;
            end else m_write = 0;
            if (vis && !(hit && mq[0].live)) mq.delete(0);
            if (hit) foreach (mq[i]) if (mq[i].wr == alu_wr) mq[i].live = 0;
            if (psh) mq.push_back('{ld_wr, ld_wd, ld_wr != '0, edge_n});
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; set_in(0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write got %b exp 0", write); end
        checks++; if (WR !== '0) begin errors++; $display("FAIL reset_WR got %0d exp 0", WR); end
        checks++; if (WD !== '0) begin errors++; $display("FAIL reset_WD got %h exp 0", WD); end
        checks++; if (pend_mask !== '0) begin errors++; $display("FAIL reset_pend got %h exp 0", pend_mask); end
        checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_qcount got %0d exp 0", q_count); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ldready got %b exp 0", ld_ready); end
        reset = 0; #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ldready got %b exp 1", ld_ready); end
    endtask

    task automatic test_reset_mid_drain();
        set_in(1, 1, 32'h1, 1, 5, 32'hAAAA0005); cyc();
        set_in(1, 1, 32'h1, 1, 6, 32'hAAAA0006); cyc();
        checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL mid_qcount got %0d exp 2", q_count); end
        checks++; if (pend_mask !== NR'(32'h60)) begin errors++; $display("FAIL mid_pend got %h exp 60", pend_mask); end
        reset = 1; set_in(0, 0, 0, 0, 0, 0); cyc();
        checks++; if (write !== 1'b0 || q_count !== 3'd0 || pend_mask !== '0) begin
            errors++; $display("FAIL mid_reset got w=%b q=%0d p=%h exp 0/0/0", write, q_count, pend_mask); end
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (write !== 1'b0) begin errors++; $display("FAIL mid_nowrite cyc %0d got w=%b WR=%0d exp w=0", i, write, WR); end
        end
    endtask

    task automatic test_idle_drain();
        set_in(0, 0, 0, 1, 7, 32'h12345678); cyc();
        checks++; if (pend_mask[7] !== 1'b1) begin errors++; $display("FAIL idle_pend7 got %b exp 1", pend_mask[7]); end
        set_in(0, 0, 0, 0, 0, 0); cyc();
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL idle_early_write got %b exp 0", write); end
        cyc();
        checks++; if (write !== 1'b1 || WR !== 5'd7 || WD !== 32'h12345678) begin
            errors++; $display("FAIL idle_drain got w=%b WR=%0d WD=%h exp 1/7/12345678", write, WR, WD); end
        checks++; if (pend_mask !== '0 || q_count !== 3'd0) begin
            errors++; $display("FAIL idle_empty got p=%h q=%0d exp 0/0", pend_mask, q_count); end
    endtask

    task automatic test_alu_priority();
        int ew[5] = '{9, 9, 9, 3, 4};
        int ed[5] = '{'h99, 'h99, 'h99, 'h33, 'h44};
        for (int i = 0; i < 5; i++) begin
            set_in(i < 3, 9, 32'h99, i < 2, (i == 0) ? 3 : 4, (i == 0) ? 32'h33 : 32'h44);
            cyc();
            checks++; if (write !== 1'b1 || WR !== AW'(ew[i]) || WD !== DW'(ed[i])) begin
                errors++; $display("FAIL prio slot %0d got w=%b WR=%0d WD=%h exp 1/%0d/%h", i, write, WR, WD, ew[i], ed[i]); end
        end
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL prio_qcount got %0d exp 0", q_count); end
    endtask

    task automatic test_squash();
        int n8 = 0;
        set_in(0, 0, 0, 1, 8, 32'hDEAD); cyc();
        set_in(1, 8, 32'hBEEF, 0, 0, 0); cyc();
        if (write && WR == 5'd8) n8++;
        checks++; if (WD !== 32'hBEEF || pend_mask[8] !== 1'b0 || q_count !== 3'd1) begin
            errors++; $display("FAIL squash_alu got WD=%h p8=%b q=%0d exp BEEF/0/1", WD, pend_mask[8], q_count); end
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (write && WR == 5'd8) n8++;
        end
        checks++; if (n8 !== 1 || q_count !== 3'd0) begin
            errors++; $display("FAIL squash_once got writes=%0d q=%0d exp 1/0", n8, q_count); end
    endtask

    task automatic test_full();
        int got[$];
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, $urandom, 1, 10 + i, 100 + i); cyc();
        end
        checks++; if (q_count !== 3'd4 || ld_ready !== 1'b0) begin
            errors++; $display("FAIL full got q=%0d rdy=%b exp 4/0", q_count, ld_ready); end
        set_in(1, 1, $urandom, 1, 20, 200); cyc();
        checks++; if (q_count !== 3'd4 || ld_ready !== 1'b0) begin
            errors++; $display("FAIL full_hold got q=%0d rdy=%b exp 4/0", q_count, ld_ready); end
        set_in(0, 0, 0, 1, 20, 200); cyc();
        if (write) got.push_back(int'(WR));
        checks++; if (q_count !== 3'd3 || ld_ready !== 1'b1) begin
            errors++; $display("FAIL full_pop got q=%0d rdy=%b exp 3/1", q_count, ld_ready); end
        cyc();
        if (write) got.push_back(int'(WR));
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (write) got.push_back(int'(WR));
        end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL full_count got %0d writes exp 5", got.size()); end
        else begin
            int ex[5] = '{10, 11, 12, 13, 20};
            for (int i = 0; i < 5; i++) begin
                checks++; if (got[i] != ex[i]) begin errors++; $display("FAIL full_order %0d got %0d exp %0d", i, got[i], ex[i]); end
            end
        end
    endtask

    task automatic test_x0();
        int nw = 0;
        set_in(1, 1, 32'h5, 1, 10, 32'h1010); cyc();
        set_in(1, 1, 32'h5, 0, 0, 0); cyc();
        set_in(1, 0, 32'h77, 0, 0, 0); cyc();
        checks++; if (write !== 1'b1 || WR !== 5'd10 || WD !== 32'h1010) begin
            errors++; $display("FAIL x0_alu_drop got w=%b WR=%0d WD=%h exp 1/10/1010", write, WR, WD); end
        set_in(0, 0, 0, 1, 0, 32'hFFFF); cyc();
        checks++; if (q_count !== 3'd1 || pend_mask !== '0) begin
            errors++; $display("FAIL x0_load_slot got q=%0d p=%h exp 1/0", q_count, pend_mask); end
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (write) nw++;
        end
        checks++; if (nw != 0 || q_count !== 3'd0) begin
            errors++; $display("FAIL x0_load_nowrite got writes=%0d q=%0d exp 0/0", nw, q_count); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            set_in($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom);
            cyc();
            checks++; if (write !== m_write || WR !== m_wr || WD !== m_wd) begin
                errors++; $display("FAIL rnd_port n=%0d got %b/%0d/%h exp %b/%0d/%h", n, write, WR, WD, m_write, m_wr, m_wd); end
            checks++; if (q_count !== 3'(mq.size()) || pend_mask !== m_pend()) begin
                errors++; $display("FAIL rnd_fifo n=%0d got q=%0d p=%h exp q=%0d p=%h", n, q_count, pend_mask, mq.size(), m_pend()); end
            checks++; if (ld_ready !== (!reset && mq.size() < DEPTH)) begin
                errors++; $display("FAIL rnd_ready n=%0d got %b", n, ld_ready); end
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_drain();
        test_idle_drain();
        test_alu_priority();
        test_squash();
        test_full();
        test_x0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Owns the single register-file write port (write/WR/WD) and shares it between two producers: the in-order ALU writeback path and the long-latency load-return path.
- ALU results always win the port. Load returns are buffered in a small FIFO and drained into idle write slots.
- Exports a pending-register mask so the hazard unit can stall readers of registers whose load data is still queued.
- Sits between the MEM/WB stage and reg_file.

Parameters:
DEPTH, 4, load-return FIFO entries (power of two, >=2)
DW, 32, data width
AW, 5, register index width (2**AW architectural registers)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU writeback request this cycle (no backpressure, always consumed)
alu_wr  input  AW  ALU destination register
alu_wd  input  DW  ALU result
ld_valid  input  1  load-return data valid
ld_ready  output  1  FIFO can accept a load return
ld_wr  input  AW  load destination register
ld_wd  input  DW  load data
write  output  1  register-file write enable (registered)
WR  output  AW  register-file write index (registered)
WD  output  DW  register-file write data (registered)
pend_mask  output  2**AW  bit r set = a live queued load targets register r (registered)
q_count  output  log2(DEPTH)+1  FIFO occupancy, including squashed entries

Behaviour:
- Reset (synchronous, clk rising edge with reset=1):
  - write=0, WR=0, WD=0, pend_mask=0, q_count=0.
  - FIFO pointers cleared; all entry live bits cleared.
  - Any in-flight queued load is discarded.
  - ld_ready=0 while reset is high.
- ld_ready = !reset && (q_count < DEPTH). Combinational from registered count only; it never depends on ld_valid.
- Push: on ld_valid && ld_ready, the entry {wr, wd, live} is written at the tail.
  - live = (ld_wr != 0).
  - An x0 load is accepted and occupies a slot, but is never written.
- Per-cycle port selection (evaluated on current state, result registered at the next edge, one-cycle latency):
  - (1) alu_valid && alu_wr != 0: the next edge gives write=1, WR=alu_wr, WD=alu_wd.
  - (2) Otherwise, if the FIFO is non-empty and the head is live: the next edge gives write=1, WR=head.wr, WD=head.wd, and the head is popped.
  - (3) Otherwise: write=0. WR and WD hold their previous values.
- A non-live head (x0 or squashed) is popped in any cycle, including cycles where the ALU owns the port. At most one pop per cycle.
- An ALU request to x0 is dropped. It does not consume the port, so a live head may drain that cycle.
- Squash: when rule (1) fires for register r, every live FIFO entry with wr==r clears its live bit at the same edge, because the ALU write is younger in program order.
  - An entry pushed in that same cycle is not squashed.
- Minimum load latency: push at edge N, pop selected in cycle N+1, write=1 visible after edge N+2.
- Simultaneous push and pop: q_count unchanged. When full with a pop, ld_ready stays 0 for that cycle (no same-cycle refill).
- Pointers wrap modulo DEPTH. q_count ranges 0..DEPTH.
- pend_mask is recomputed each edge from the post-update FIFO: the OR of one-hot(wr) over live entries. Bit 0 is always 0.
- Loads to the same register are drained in FIFO order, so the last-pushed value is written last.

Test Plan:
- Reset mid-drain: push loads r5=0xAAAA0005 and r6=0xAAAA0006, assert reset one cycle -> write=0, q_count=0, pend_mask=0; neither load is ever written.
- Idle drain: single load r7=0x12345678, no ALU traffic -> pend_mask[7]=1 after the push edge; write=1, WR=7, WD=0x12345678 exactly 2 edges after the push; pend_mask returns to 0.
- ALU priority and backfill: queue r3=0x33 and r4=0x44; ALU writes r9=0x99 for 3 consecutive cycles. Required port sequence:
  - r9 writes on the ALU cycles;
  - r3 in the first free slot;
  - r4 in the next free slot;
  - q_count reaches 0.
- Squash: queue r8=0xDEAD, then ALU writes r8=0xBEEF before the drain. Required:
  - exactly one write to r8, with WD=0xBEEF;
  - pend_mask[8] clears at the ALU edge;
  - the squashed entry is popped with no write.
- Full/backpressure: with ALU continuously busy (alu_wr=1), push 4 loads -> ld_ready=0, q_count=4; the 5th ld_valid is held off. Release the ALU -> entries drain in order and ld_ready returns to 1 after the first pop.
- x0 handling: alu_wr=0 together with a queued live head -> the head drains that cycle. A load to x0 occupies a slot, pops, and never asserts write.
